// File: rtl/interrupt_controller_if.sv
// Handshake bundle between interrupt_controller and control_unit.
// master = control_unit side, slave = interrupt_controller side.
interface interrupt_controller_if;
    logic        sample;
    logic        int_ack;
    logic        reti;
    logic        int_req;
    logic [15:0] int_vector;
    logic [2:0]  int_src_id;
    logic [1:0]  in_service;

    modport master (
        output sample, int_ack, reti,
        input  int_req, int_vector, int_src_id, in_service
    );

    modport slave (
        input  sample, int_ack, reti,
        output int_req, int_vector, int_src_id, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// 8051 interrupt scheduler: edge-latched sources, IE/IP masking, req/ack vector handoff.
// Define INTC_NESTED_PRIO_EN for two-level priority with nesting; default is single level.
module interrupt_controller #(
    parameter int          NUM_SRC    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_level,
    input  logic [7:0]         ie,
    input  logic [NUM_SRC-1:0] ip,
    interrupt_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] pend, prev, clr, elig, allowed, cand, prio_eff;
    logic [1:0]         is_q, is_pop, is_nxt;
    logic               req_q, prio_q;
    logic [15:0]        vec_q, vec_calc;
    logic [2:0]         id_q, win_id;
    logic               take, issue, win_found, win_hi;
    logic               unused_ie;

    assign unused_ie = ^ie;

`ifdef INTC_NESTED_PRIO_EN
    assign prio_eff = ip;
`else
    logic unused_ip;
    assign unused_ip = ^ip;
    assign prio_eff  = '0;
`endif

    // Per-source edge detect and pending latch; a new edge beats an ack clear.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        assign clr[g] = take && (id_q == 3'(g));
        always_ff @(posedge clock) begin
            if (reset) begin
                prev[g] <= 1'b0;
                pend[g] <= 1'b0;
            end else begin
                prev[g] <= src_level[g];
                if (src_level[g] && !prev[g]) pend[g] <= 1'b1;
                else if (clr[g])              pend[g] <= 1'b0;
            end
        end
    end

    assign elig = pend & ie[NUM_SRC-1:0] & {NUM_SRC{ie[7]}};

    // RETI pops before anything else looks at the in-service stack.
    always_comb begin
        is_pop = is_q;
        if (bus.reti) begin
            if (is_q[1]) is_pop[1] = 1'b0;
            else         is_pop[0] = 1'b0;
        end
    end

    always_comb begin
        allowed = '0;
`ifdef INTC_NESTED_PRIO_EN
        if (is_pop == 2'b00)      allowed = elig;
        else if (is_pop == 2'b01) allowed = elig & ip;
`else
        if (is_pop == 2'b00)      allowed = elig;
`endif
    end

    always_comb begin
        win_hi    = |(allowed & prio_eff);
        cand      = win_hi ? (allowed & prio_eff) : allowed;
        win_found = |cand;
        win_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (cand[i]) win_id = 3'(i);
    end

    assign vec_calc = VEC_BASE + 16'(win_id) * VEC_STRIDE;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ACTIVE: begin
                if (bus.sample && win_found) state_nxt = S_REQ;
                else if (is_pop == 2'b00)    state_nxt = S_IDLE;
            end
            S_REQ:   if (bus.int_ack) state_nxt = S_ACTIVE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        take  = (state == S_REQ) && bus.int_ack;
        issue = ((state == S_IDLE) || (state == S_ACTIVE)) && bus.sample && win_found;
    end

    assign is_nxt = is_pop | (take ? (prio_q ? 2'b10 : 2'b01) : 2'b00);

    // Vector/id/priority are captured at selection and frozen through S_REQ.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q  <= 1'b0;
            vec_q  <= '0;
            id_q   <= '0;
            prio_q <= 1'b0;
            is_q   <= '0;
        end else begin
            is_q <= is_nxt;
            if (issue) begin
                req_q  <= 1'b1;
                vec_q  <= vec_calc;
                id_q   <= win_id;
                prio_q <= win_hi;
            end else if (take) begin
                req_q <= 1'b0;
            end
        end
    end

    assign bus.int_req    = req_q;
    assign bus.int_vector = vec_q;
    assign bus.int_src_id = id_q;
    assign bus.in_service = is_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: stimulus queues expected {vector,id}; monitor checks each new int_req.
module tb_interrupt_controller;
    typedef struct {
        logic [15:0] vec;
        logic [2:0]  id;
    } exp_t;

`ifdef INTC_NESTED_PRIO_EN
    localparam bit NESTED = 1'b1;
`else
    localparam bit NESTED = 1'b0;
`endif

    logic       clock, reset;
    logic [4:0] src_level, ip;
    logic [7:0] ie;
    int         checks, passes;
    exp_t       q[$];
    logic       req_seen;

    interrupt_controller_if bus();

    interrupt_controller dut (
        .clock(clock), .reset(reset), .src_level(src_level),
        .ie(ie), .ip(ip), .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every new request must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.int_req && !req_seen) begin
            if (q.size() == 0) begin
                check("unexpected_req", 32'(bus.int_req), 32'(0));
            end else begin
                e = q.pop_front();
                check("vector", 32'(bus.int_vector), 32'(e.vec));
                check("src_id", 32'(bus.int_src_id), 32'(e.id));
            end
        end
        req_seen = bus.int_req;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_sample();
        bus.sample = 1'b1; tick(); bus.sample = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        bus.reti = 1'b1; tick(); bus.reti = 1'b0;
    endtask

    task automatic expect_req(input logic [15:0] vec, input logic [2:0] id);
        exp_t e;
        e.vec = vec;
        e.id  = id;
        q.push_back(e);
        pulse_sample();
        check("req_latency", 32'(bus.int_req), 32'(1));
        tick();
    endtask

    task automatic ack_expect(input logic [1:0] ins);
        pulse_ack();
        check("req_drop", 32'(bus.int_req), 32'(0));
        check("in_service", 32'(bus.in_service), 32'(ins));
    endtask

    initial begin
        checks = 0; passes = 0; req_seen = 1'b0;
        reset = 1'b1; src_level = '0; ie = '0; ip = '0;
        bus.sample = 1'b0; bus.int_ack = 1'b0; bus.reti = 1'b0;
        tick(); tick();
        check("rst_req", 32'(bus.int_req), 32'(0));
        check("rst_vec", 32'(bus.int_vector), 32'(0));
        check("rst_id", 32'(bus.int_src_id), 32'(0));
        check("rst_ins", 32'(bus.in_service), 32'(0));
        reset = 1'b0; tick();

        // 1: single low source
        ie = 8'h81; src_level[0] = 1'b1; tick();
        expect_req(16'h0003, 3'd0);
        ack_expect(2'b01);
        pulse_reti();
        check("reti_pop", 32'(bus.in_service), 32'(0));

        // 2: priority / index selection, then the leftover source
        ie = 8'h8A; ip = 5'b01000; src_level[1] = 1'b1; src_level[3] = 1'b1; tick();
        expect_req(NESTED ? 16'h001B : 16'h000B, NESTED ? 3'd3 : 3'd1);
        ack_expect(NESTED ? 2'b10 : 2'b01);
        pulse_reti();
        expect_req(NESTED ? 16'h000B : 16'h001B, NESTED ? 3'd1 : 3'd3);
        ack_expect(2'b01);
        pulse_reti();
        check("reti_pop2", 32'(bus.in_service), 32'(0));
        src_level = '0;

        // 3: EA gates everything
        ie = 8'h10; ip = '0; src_level[4] = 1'b1; tick();
        pulse_sample();
        check("ea_off_req", 32'(bus.int_req), 32'(0));
        tick();
        check("ea_off_req2", 32'(bus.int_req), 32'(0));
        ie = 8'h90;
        expect_req(16'h0023, 3'd4);
        ack_expect(2'b01);

        // 4: nesting (or its absence) with a low level in service
        ip = 5'b00100; ie = 8'h84; src_level[2] = 1'b1; tick();
`ifdef INTC_NESTED_PRIO_EN
        expect_req(16'h0013, 3'd2);
        ack_expect(2'b11);
        pulse_reti();
        check("nest_pop1", 32'(bus.in_service), 32'(2'b01));
        pulse_reti();
        check("nest_pop2", 32'(bus.in_service), 32'(0));
`else
        pulse_sample();
        check("no_nest_req", 32'(bus.int_req), 32'(0));
        pulse_reti();
        check("flat_pop", 32'(bus.in_service), 32'(0));
        expect_req(16'h0013, 3'd2);
        ack_expect(2'b01);
        pulse_reti();
        check("flat_pop2", 32'(bus.in_service), 32'(0));
`endif
        src_level = '0; ip = '0; tick();

        // 5: outputs frozen in S_REQ, then reset abort
        ie = 8'h81; src_level[0] = 1'b1; tick();
        expect_req(16'h0003, 3'd0);
        ie = 8'h00; tick(); tick();
        pulse_sample();
        check("hold_req", 32'(bus.int_req), 32'(1));
        check("hold_vec", 32'(bus.int_vector), 32'(16'h0003));
        check("hold_id", 32'(bus.int_src_id), 32'(0));
        ack_expect(2'b01);
        pulse_reti();
        ie = 8'h81; src_level[0] = 1'b0; tick();
        src_level[0] = 1'b1; tick();
        expect_req(16'h0003, 3'd0);
        reset = 1'b1; src_level = '0; tick();
        check("abort_req", 32'(bus.int_req), 32'(0));
        check("abort_vec", 32'(bus.int_vector), 32'(0));
        check("abort_id", 32'(bus.int_src_id), 32'(0));
        check("abort_ins", 32'(bus.in_service), 32'(0));
        reset = 1'b0; tick();

        // 6: new edge coincident with ack of the same source keeps it pending
        ie = 8'h81; src_level[0] = 1'b1; tick();
        expect_req(16'h0003, 3'd0);
        src_level[0] = 1'b0; tick();
        src_level[0] = 1'b1;
        ack_expect(2'b01);
        pulse_reti();
        check("set_wins_pop", 32'(bus.in_service), 32'(0));
        expect_req(16'h0003, 3'd0);
        ack_expect(2'b01);
        pulse_reti();

        tick(); tick();
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
